// File: rtl/flex_counter_ud.sv
// flex_counter_ud: parameterised up/down counter over the range 1..rollover_val
// with clear/load priority, optional saturation, registered range flags and a
// one-cycle wrap pulse for cascading.
module flex_counter_ud #(
    parameter int unsigned NUM_CNT_BITS = 4,
    parameter int unsigned SATURATE     = 0
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic                    count_enable,
    input  logic                    count_down,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    bottom_flag,
    output logic                    wrap_pulse
);

    localparam int unsigned W = NUM_CNT_BITS;

    logic [W-1:0] count_q, count_d;
    logic         rollover_q, rollover_d;
    logic         bottom_q, bottom_d;
    logic         wrap_q, wrap_d;
    logic         sat;

    assign sat = (SATURATE != 0);

    // Next count: clear > load > enabled step > hold; a zero range freezes stepping.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (count_enable && (rollover_val != '0)) begin
            if (!count_down) begin
                if (count_q >= rollover_val) begin
                    if (sat) begin
                        count_d = rollover_val;
                    end else begin
                        count_d = W'(1);
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + W'(1);
                end
            end else begin
                if (count_q > rollover_val) begin
                    // Out-of-range values re-enter at the top; not a wrap.
                    count_d = rollover_val;
                end else if (count_q <= W'(1)) begin
                    if (!sat) begin
                        count_d = rollover_val;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q - W'(1);
                end
            end
        end
        rollover_d = (count_d == rollover_val);
        bottom_d   = (count_d == W'(1));
    end

    // State and flag registers with asynchronous reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q    <= '0;
            rollover_q <= 1'b0;
            bottom_q   <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            count_q    <= count_d;
            rollover_q <= rollover_d;
            bottom_q   <= bottom_d;
            wrap_q     <= wrap_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = rollover_q;
    assign bottom_flag   = bottom_q;
    assign wrap_pulse    = wrap_q;

endmodule

// File: tb/tb_flex_counter_ud.sv
// tb_flex_counter_ud: checks a wrapping and a saturating instance driven by the
// same inputs, with directed tables, hand sequences and random stimulus.
module tb_flex_counter_ud;

    logic       clk;
    logic       n_rst;
    logic       clear, load, count_enable, count_down;
    logic [3:0] load_val, rollover_val;
    logic [3:0] cnt0, cnt1;
    logic       rf0, rf1, bf0, bf1, wp0, wp1;

    int errors = 0;
    int checks = 0;

    // Reference state for [0]=wrapping, [1]=saturating instance.
    int m_cnt [2];
    bit m_rf  [2];
    bit m_bf  [2];
    bit m_wp  [2];

    flex_counter_ud #(.NUM_CNT_BITS(4), .SATURATE(0)) dut0 (
        .clk(clk), .n_rst(n_rst), .clear(clear), .load(load),
        .count_enable(count_enable), .count_down(count_down),
        .load_val(load_val), .rollover_val(rollover_val),
        .count_out(cnt0), .rollover_flag(rf0), .bottom_flag(bf0), .wrap_pulse(wp0)
    );

    flex_counter_ud #(.NUM_CNT_BITS(4), .SATURATE(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .clear(clear), .load(load),
        .count_enable(count_enable), .count_down(count_down),
        .load_val(load_val), .rollover_val(rollover_val),
        .count_out(cnt1), .rollover_flag(rf1), .bottom_flag(bf1), .wrap_pulse(wp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit cl; bit ld; bit en; bit dn;
        int lv; int rv;
        int cnt; bit rf; bit bf; bit wp;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural next-count rule on plain integers.
    function automatic int calc(input int c, input int rv, input bit sat, input bit cl,
                                input bit ld, input int lv, input bit en, input bit dn,
                                output bit wp);
        wp = 1'b0;
        if (cl) return 0;
        if (ld) return lv;
        if (!en || rv == 0) return c;
        if (!dn) begin
            if (c < rv) return c + 1;
            if (sat) return rv;
            wp = 1'b1;
            return 1;
        end
        if (c > rv) return rv;
        if (c > 1) return c - 1;
        if (sat) return c;
        wp = 1'b1;
        return rv;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_rf[k] = 0; m_bf[k] = 0; m_wp[k] = 0;
        end
    endtask

    // One clock edge: evaluate the model on the inputs present at the edge.
    task automatic tick();
        int nx [2];
        bit w  [2];
        int rv;
        rv = int'(rollover_val);
        for (int k = 0; k < 2; k++)
            nx[k] = calc(m_cnt[k], rv, k == 1, clear, load, int'(load_val),
                         count_enable, count_down, w[k]);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = nx[k];
            m_wp[k]  = w[k];
            m_rf[k]  = (nx[k] == rv);
            m_bf[k]  = (nx[k] == 1);
        end
    endtask

    task automatic check_model(input string nm, input bit both);
        if (both) begin
            check({nm, ".cnt0"}, int'(cnt0), m_cnt[0]);
            check({nm, ".rf0"},  int'(rf0),  int'(m_rf[0]));
            check({nm, ".bf0"},  int'(bf0),  int'(m_bf[0]));
            check({nm, ".wp0"},  int'(wp0),  int'(m_wp[0]));
        end
        check({nm, ".cnt1"}, int'(cnt1), m_cnt[1]);
        check({nm, ".rf1"},  int'(rf1),  int'(m_rf[1]));
        check({nm, ".bf1"},  int'(bf1),  int'(m_bf[1]));
        check({nm, ".wp1"},  int'(wp1),  int'(m_wp[1]));
    endtask

    task automatic drive(input bit cl, input bit ld, input bit en, input bit dn,
                         input int lv, input int rv);
        clear = cl; load = ld; count_enable = en; count_down = dn;
        load_val = 4'(lv); rollover_val = 4'(rv);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, ".cnt0"}, int'(cnt0), 0);
        check({nm, ".rf0"},  int'(rf0),  0);
        check({nm, ".bf0"},  int'(bf0),  0);
        check({nm, ".wp0"},  int'(wp0),  0);
        check({nm, ".cnt1"}, int'(cnt1), 0);
        check({nm, ".wp1"},  int'(wp1),  0);
    endtask

    vec_t vecs [$];

    initial begin
        // Wrapping-instance table: {cl,ld,en,dn, lv,rv, cnt,rf,bf,wp}
        vecs.push_back('{0,0,1,0, 0,5,  1,0,1,0});
        vecs.push_back('{0,0,1,0, 0,5,  2,0,0,0});
        vecs.push_back('{0,0,1,0, 0,5,  3,0,0,0});
        vecs.push_back('{0,0,1,0, 0,5,  4,0,0,0});
        vecs.push_back('{0,0,1,0, 0,5,  5,1,0,0});
        vecs.push_back('{0,0,1,0, 0,5,  1,0,1,1});
        vecs.push_back('{0,1,0,0, 2,5,  2,0,0,0});
        vecs.push_back('{0,0,1,1, 0,5,  1,0,1,0});
        vecs.push_back('{0,0,1,1, 0,5,  5,1,0,1});
        vecs.push_back('{0,0,1,1, 0,5,  4,0,0,0});
        vecs.push_back('{1,1,1,0, 7,5,  0,0,0,0});
        vecs.push_back('{0,1,1,0, 9,5,  9,0,0,0});
        vecs.push_back('{0,0,0,0, 0,9,  9,1,0,0});
        vecs.push_back('{0,1,0,0, 12,5, 12,0,0,0});
        vecs.push_back('{0,0,1,0, 0,5,  1,0,1,1});
        vecs.push_back('{0,1,0,0, 12,5, 12,0,0,0});
        vecs.push_back('{0,0,1,1, 0,5,  5,1,0,0});
        vecs.push_back('{0,1,0,0, 12,5, 12,0,0,0});
        vecs.push_back('{0,0,1,0, 0,0,  12,0,0,0});
        vecs.push_back('{0,0,1,1, 0,0,  12,0,0,0});
        vecs.push_back('{0,0,0,0, 0,5,  12,0,0,0});

        n_rst = 1'b0;
        drive(0, 0, 0, 0, 0, 5);
        model_reset();
        #1;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        check_all_zero("reset_held");
        n_rst = 1'b1;

        // Directed table on the wrapping instance; saturating one tracks the model.
        for (int i = 0; i < vecs.size(); i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            drive(vecs[i].cl, vecs[i].ld, vecs[i].en, vecs[i].dn, vecs[i].lv, vecs[i].rv);
            tick();
            check({nm, ".cnt"}, int'(cnt0), vecs[i].cnt);
            check({nm, ".rf"},  int'(rf0),  int'(vecs[i].rf));
            check({nm, ".bf"},  int'(bf0),  int'(vecs[i].bf));
            check({nm, ".wp"},  int'(wp0),  int'(vecs[i].wp));
            check_model(nm, 1'b0);
        end

        // Saturation: up past the top holds 5, down from 1 holds 1.
        drive(1, 0, 0, 0, 0, 5);
        tick();
        for (int i = 1; i <= 7; i++) begin
            drive(0, 0, 1, 0, 0, 5);
            tick();
            check($sformatf("sat_up%0d.cnt", i), int'(cnt1), (i < 5) ? i : 5);
            check($sformatf("sat_up%0d.wp", i),  int'(wp1), 0);
            check($sformatf("sat_up%0d.rf", i),  int'(rf1), (i >= 5) ? 1 : 0);
        end
        drive(0, 1, 0, 0, 1, 5);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 1, 0, 5);
            tick();
            check($sformatf("sat_dn%0d.cnt", i), int'(cnt1), 1);
            check($sformatf("sat_dn%0d.bf", i),  int'(bf1), 1);
            check($sformatf("sat_dn%0d.wp", i),  int'(wp1), 0);
        end

        // Reset asserted between edges while counting at 3.
        drive(1, 0, 0, 0, 0, 5);
        tick();
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 1, 0, 0, 5);
            tick();
        end
        check("pre_rst.cnt0", int'(cnt0), 3);
        #2;
        n_rst = 1'b0;
        #1;
        check_all_zero("mid_rst");
        model_reset();
        #1;
        n_rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("post_rst%0d.cnt0", i), int'(cnt0), i);
            check($sformatf("post_rst%0d.cnt1", i), int'(cnt1), i);
        end

        // Random stimulus against the reference model.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            drive(r < 4, (r >= 4) && (r < 12), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15))
                                               : int'(rollover_val));
            if (i == 0) rollover_val = 4'd6;
            tick();
            check_model($sformatf("rnd%0d", i), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
